eth_pixel_packer: RTL and testbench
===================================

# eth_pixel_packer

Assembles the Ethernet receive byte stream into 768-bit framebuffer words (32 pixels × 24 bit) and issues single-cycle RAM write requests on the `e_write_*` port of the RAM initialiser. It sits directly upstream of that port. It stays idle until the RAM initialiser raises `ram_init`. It also enforces the minimum spacing between writes that the memory write path requires.

## Interface
- `BYTES_PER_WORD`, 96: bytes per 768-bit write word.
- `WORDS_PER_FRAME`, 24576: words per 1024×768 frame.
- `ADDR_STEP`, 16: address increment per word.
- `WRITE_GAP`, 100: minimum idle cycles after each write pulse.

Ports:
- `clk`  in  1  system clock; one clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `ram_init`  in  1  high once the initial RAM fill is complete; enables the block.
- `rx_valid`  in  1  `rx_data` is valid this cycle.
- `rx_data`  in  8  received payload byte.
- `rx_sof`  in  1  qualifies `rx_valid`: this byte is byte 0 of a frame.
- `rx_ready`  out  1  block can accept a byte this cycle.
- `e_write_ram`  out  1  single-cycle write strobe.
- `e_write_data`  out  768  write word.
- `e_write_address`  out  32  write address, equal to word_index × `ADDR_STEP`.
- `frame_done`  out  1  single-cycle pulse, coincident with the last word's write.
- `sof_error`  out  1  single-cycle pulse: SOF arrived while a frame was incomplete.

## Operation
- A byte is accepted when `rx_valid & rx_ready`.
- Accepted byte k of a word is stored at `e_write_data` bits [8k+7:8k]. Byte 0 goes to the LSBs; pixel p occupies bits [24p+23:24p].

FSM states:
- **IDLE**: `rx_ready`=0. Transition to FILL when `ram_init`=1.
- **FILL**: `rx_ready`=1. Holds `byte_cnt` (7 bit). When byte `BYTES_PER_WORD`-1 is accepted, transition to WRITE.
- **WRITE**: one cycle. `e_write_ram`=1. Data and address are valid this cycle. `word_idx` then increments, and `byte_cnt` clears to 0. Transition to GAP.
- **GAP**: `rx_ready`=0. Counter (7 bit) runs for `WRITE_GAP` cycles, then transition to FILL.

Counters and address:
- `word_idx` is 15 bit and wraps after `WORDS_PER_FRAME`-1.
- The WRITE of word `WORDS_PER_FRAME`-1 also asserts `frame_done`, and `word_idx` returns to 0.
- `e_write_address` is `{17'b0, word_idx} × ADDR_STEP`, computed in 32 bit, registered, and updated only on entry to WRITE.
- `e_write_data` and `e_write_address` hold their values between writes.

Boundary conditions:
- Byte accepted with `rx_sof`=1 while `byte_cnt`≠0 or `word_idx`≠0:
  - Partial data is discarded.
  - `word_idx` and `byte_cnt` are set to 0.
  - This byte is stored as byte 0 of word 0.
  - `sof_error` pulses on the next cycle.
- `rx_sof`=1 at `byte_cnt`=0 and `word_idx`=0: normal operation, no error.
- `ram_init` falls in any state: go to IDLE next cycle, discard the partial word, clear `word_idx`, and suppress any pending write.
- `reset`: all outputs are 0, including `e_write_data` and `e_write_address`. Counters are 0 and the FSM is in IDLE. Reset has priority over every other event, including an in-progress WRITE.

## Timing
- Last byte of a word accepted at cycle t: `e_write_ram`=1 at t+1 for exactly one cycle.
- `rx_ready` is 0 from t+1 through t+1+`WRITE_GAP` and returns to 1 at t+2+`WRITE_GAP`.
- Write pulses are therefore separated by at least `WRITE_GAP`+`BYTES_PER_WORD` cycles.
- `rx_ready` is a registered function of state only and does not depend on `rx_valid` combinationally.
- `frame_done` and `e_write_ram` are high in the same cycle.
- `sof_error` is high at t+1 for an SOF byte accepted at t.

## Structure
- Shared package `fb_pkg` holds the frame constants (1024, 768, 24-bit pixel, 32 pixels per word, word count 24576, `ADDR_STEP` 16) and the FSM state encoding. The RAM initialiser uses the same values.
- Sub-module `byte_word_assembler`: 96-byte shift/insert register with `byte_cnt`, a clear input, and a word-complete flag.
- The FSM, gap timer, and address generator live in the top level.

## Test plan
- Reset, then `ram_init`=0 with `rx_valid`=1 held → `rx_ready` stays 0, no writes, all outputs 0.
- `ram_init`=1; SOF followed by 96 bytes with values 0x00..0x5F → one `e_write_ram` pulse, address 0x0, data bits [7:0]=0x00 and [767:760]=0x5F, then `rx_ready` low for exactly 100 cycles.
- Stream a full frame of 24576 words with `rx_valid` continuously high → last write address 0x5FFF0, `frame_done` coincident with that write, next word written at address 0.
- 50 bytes, then an SOF byte 0xAA, then 95 more bytes → `sof_error` pulses once, first write is at address 0 with bits [7:0]=0xAA.
- `ram_init` deasserted in GAP after word 3 → IDLE, no further writes. After re-assertion, a new word is written at address 0.
- `reset` asserted in the same cycle as WRITE → `e_write_ram` 0 the following cycle, outputs cleared, FSM in IDLE.

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - framebuffer geometry, write-path constants and packer FSM encoding
package fb_pkg;

  localparam int H_RES           = 1024;
  localparam int V_RES           = 768;
  localparam int PIXEL_BITS      = 24;
  localparam int PIXELS_PER_WORD = 32;
  localparam int WORD_BITS       = PIXEL_BITS * PIXELS_PER_WORD;
  localparam int BYTES_PER_WORD  = WORD_BITS / 8;
  localparam int FRAME_WORDS     = (H_RES * V_RES) / PIXELS_PER_WORD;
  localparam int ADDR_STEP       = 16;
  localparam int GAP_CYCLES      = 100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_WRITE,
    ST_GAP
  } pack_state_e;

  // Byte address of a framebuffer word, widened to 32 bit before scaling.
  function automatic logic [31:0] word_addr(input logic [14:0] idx);
    return {17'b0, idx} * 32'(ADDR_STEP);
  endfunction

endpackage

// File: rtl/eth_pixel_packer_asm.sv
// rtl/eth_pixel_packer_asm.sv - byte_word_assembler: packs 96 received bytes into one 768-bit word
module byte_word_assembler
  import fb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic                 restart,
  input  logic [7:0]           data,
  output logic [WORD_BITS-1:0] word_next,
  output logic [6:0]           byte_cnt,
  output logic                 word_complete
);

  logic [WORD_BITS-1:0] word_q;

  // Bytes enter at the top and shift down, so after 96 inserts byte 0 sits in the LSBs.
  // A restart drops whatever partial word was collected and begins again from this byte.
  assign word_next     = restart ? {data, {(WORD_BITS-8){1'b0}}} : {data, word_q[WORD_BITS-1:8]};
  assign word_complete = wr_en && !restart && (byte_cnt == 7'(BYTES_PER_WORD - 1));

  // Shift register and byte counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q   <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      word_q   <= '0;
      byte_cnt <= '0;
    end else if (wr_en) begin
      word_q <= word_next;
      if (restart)            byte_cnt <= 7'd1;
      else if (word_complete) byte_cnt <= '0;
      else                    byte_cnt <= byte_cnt + 7'd1;
    end
  end

endmodule

// File: rtl/eth_pixel_packer.sv
// rtl/eth_pixel_packer.sv - packs the Ethernet byte stream into framebuffer write requests
module eth_pixel_packer
  import fb_pkg::*;
#(
  parameter int WORDS_PER_FRAME = FRAME_WORDS,
  parameter int WRITE_GAP       = GAP_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ram_init,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 rx_sof,
  output logic                 rx_ready,
  output logic                 e_write_ram,
  output logic [WORD_BITS-1:0] e_write_data,
  output logic [31:0]          e_write_address,
  output logic                 frame_done,
  output logic                 sof_error
);

  pack_state_e          state_q, state_d;
  logic [6:0]           byte_cnt;
  logic [6:0]           gap_cnt;
  logic [14:0]          word_idx;
  logic [WORD_BITS-1:0] word_next;
  logic                 word_complete;
  logic                 accept;
  logic                 sof_err;
  logic                 last_word;
  logic                 asm_clear;

  // Bytes presented while ram_init has just dropped are ignored.
  assign accept    = (state_q == ST_FILL) && rx_valid && ram_init;
  assign sof_err   = accept && rx_sof && ((byte_cnt != 7'd0) || (word_idx != 15'd0));
  assign last_word = (word_idx == 15'(WORDS_PER_FRAME - 1));
  assign asm_clear = (state_q != ST_FILL) || !ram_init;

  byte_word_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .clear         (asm_clear),
    .wr_en         (accept),
    .restart       (accept && rx_sof),
    .data          (rx_data),
    .word_next     (word_next),
    .byte_cnt      (byte_cnt),
    .word_complete (word_complete)
  );

  // Next-state logic; losing ram_init overrides everything, including a pending write.
  always_comb begin
    state_d = state_q;
    if (!ram_init) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_FILL;
        ST_FILL:  if (word_complete) state_d = ST_WRITE;
        ST_WRITE: state_d = ST_GAP;
        ST_GAP:   if (gap_cnt == 7'(WRITE_GAP - 1)) state_d = ST_FILL;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered outputs; write data/address only load on entry to WRITE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      gap_cnt         <= '0;
      word_idx        <= '0;
      rx_ready        <= 1'b0;
      e_write_ram     <= 1'b0;
      e_write_data    <= '0;
      e_write_address <= '0;
      frame_done      <= 1'b0;
      sof_error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_ready    <= (state_d == ST_FILL);
      e_write_ram <= (state_d == ST_WRITE);
      frame_done  <= (state_d == ST_WRITE) && last_word;
      sof_error   <= sof_err;
      gap_cnt     <= (state_q == ST_GAP) ? gap_cnt + 7'd1 : 7'd0;

      if ((state_q == ST_FILL) && (state_d == ST_WRITE)) begin
        e_write_data    <= word_next;
        e_write_address <= word_addr(word_idx);
      end

      if (!ram_init || sof_err)     word_idx <= '0;
      else if (state_q == ST_WRITE) word_idx <= last_word ? 15'd0 : word_idx + 15'd1;
    end
  end

endmodule

// File: tb/tb_eth_pixel_packer.sv
// tb/tb_eth_pixel_packer.sv - self-checking bench for eth_pixel_packer
module tb_eth_pixel_packer;

  localparam int WPF = 4;
  localparam int GAP = 100;
  localparam int BPW = 96;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ram_init = 1'b0;
  logic         rx_valid = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_sof = 1'b0;
  logic         rx_ready;
  logic         e_write_ram;
  logic [767:0] e_write_data;
  logic [31:0]  e_write_address;
  logic         frame_done;
  logic         sof_error;

  always #5 clk = ~clk;

  eth_pixel_packer #(.WORDS_PER_FRAME(WPF), .WRITE_GAP(GAP)) dut (
    .clk             (clk),
    .reset           (reset),
    .ram_init        (ram_init),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rx_sof          (rx_sof),
    .rx_ready        (rx_ready),
    .e_write_ram     (e_write_ram),
    .e_write_data    (e_write_data),
    .e_write_address (e_write_address),
    .frame_done      (frame_done),
    .sof_error       (sof_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [767:0] act, input logic [767:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a byte queue per word, a word counter and a not-ready countdown.
  bit           live = 1'b0;
  logic         exp_ready = 1'b0, exp_wr = 1'b0, exp_done = 1'b0, exp_serr = 1'b0;
  logic [767:0] exp_data = '0;
  logic [31:0]  exp_addr = '0;
  logic [7:0]   q[$];
  int           m_word = 0;
  int           m_busy = 0;
  bit           acc, n_ready, n_wr, n_done, n_serr;

  // Predict the outputs of the next cycle from the inputs seen at this edge.
  always @(posedge clk) begin
    if (reset) begin
      live = 1'b1;
      q.delete();
      m_word = 0; m_busy = 0;
      exp_ready = 0; exp_wr = 0; exp_done = 0; exp_serr = 0;
      exp_data = '0; exp_addr = '0;
    end else if (live) begin
      acc = exp_ready && rx_valid && ram_init;
      n_wr = 0; n_done = 0; n_serr = 0; n_ready = 0;
      if (!ram_init) begin
        q.delete();
        m_word = 0; m_busy = 0;
      end else begin
        if (acc) begin
          if (rx_sof && (q.size() != 0 || m_word != 0)) begin
            n_serr = 1;
            q.delete();
            m_word = 0;
          end
          q.push_back(rx_data);
          if (q.size() == BPW) begin
            n_wr = 1;
            for (int k = 0; k < BPW; k++) exp_data[8*k +: 8] = q[k];
            exp_addr = 32'(m_word * 16);
            n_done = (m_word == WPF - 1);
            m_word = (m_word + 1) % WPF;
            q.delete();
            m_busy = GAP;
          end
        end
        if (n_wr) n_ready = 0;
        else if (m_busy > 0) begin m_busy--; n_ready = 0; end
        else n_ready = 1;
      end
      exp_ready = n_ready; exp_wr = n_wr; exp_done = n_done; exp_serr = n_serr;
    end
  end

  int           wr_count = 0, done_count = 0, serr_count = 0;

  // Compare every cycle mid-period, and log write/error events for directed checks.
  always @(negedge clk) begin
    if (live) begin
      chk("rx_ready", rx_ready, exp_ready);
      chk("e_write_ram", e_write_ram, exp_wr);
      chk("frame_done", frame_done, exp_done);
      chk("sof_error", sof_error, exp_serr);
      chk("e_write_data", e_write_data, exp_data);
      chk("e_write_address", e_write_address, exp_addr);
    end
    if (e_write_ram === 1'b1) wr_count++;
    if (e_write_ram === 1'b1 && frame_done === 1'b1) done_count++;
    if (sof_error === 1'b1) serr_count++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    int n = 0;
    rx_valid = 1'b1; rx_data = d; rx_sof = s;
    while (rx_ready !== 1'b1 && n < 400) begin tick(); n++; end
    chk("send_ready_wait", rx_ready, 1'b1);
    tick();
  endtask

  task automatic send_word(input int base);
    for (int k = 0; k < BPW; k++) send(8'(base + k), 1'b0);
  endtask

  int n, snap_wr, snap_done, snap_serr;

  initial begin
    // Reset, then idle with ram_init low and rx_valid held high.
    repeat (3) tick();
    reset = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (20) tick();
    chk("idle_no_write", 32'(wr_count), 0);
    chk("idle_ready", rx_ready, 1'b0);
    chk("reset_data", e_write_data, '0);
    chk("reset_addr", e_write_address, 32'h0);

    // First word 0x00..0x5F starting with SOF.
    ram_init = 1'b1;
    send(8'h00, 1'b1);
    for (int k = 1; k < BPW; k++) send(8'(k), 1'b0);
    chk("w0_strobe", e_write_ram, 1'b1);
    chk("w0_addr", e_write_address, 32'h0);
    chk("w0_byte0", e_write_data[7:0], 8'h00);
    chk("w0_byte48", e_write_data[391:384], 8'h30);
    chk("w0_byte95", e_write_data[767:760], 8'h5F);
    rx_valid = 1'b0;
    n = 0;
    tick();
    while (rx_ready !== 1'b1 && n < 300) begin n++; tick(); end
    chk("gap_len", 32'(n), 100);

    // Rest of the frame with rx_valid held; last word flags frame_done, then wraps to 0.
    snap_done = done_count;
    for (int w = 1; w <= 3; w++) send_word(w * 16);
    chk("frame_done_pulse", frame_done, 1'b1);
    chk("frame_last_addr", e_write_address, 32'h30);
    send_word(8'h40);
    chk("wrap_addr", e_write_address, 32'h0);
    chk("wrap_no_done", frame_done, 1'b0);
    chk("frame_done_count", 32'(done_count - snap_done), 1);

    // SOF in the middle of a word restarts at word 0.
    snap_serr = serr_count;
    for (int k = 0; k < 50; k++) send(8'(k + 8'h80), 1'b0);
    send(8'hAA, 1'b1);
    for (int k = 0; k < 95; k++) send(8'(k + 1), 1'b0);
    chk("sof_err_count", 32'(serr_count - snap_serr), 1);
    chk("sof_word_addr", e_write_address, 32'h0);
    chk("sof_byte0", e_write_data[7:0], 8'hAA);
    chk("sof_byte1", e_write_data[15:8], 8'h01);

    // Drop ram_init in the gap after word 3; nothing more is written until re-enabled.
    for (int w = 1; w <= 3; w++) send_word(w * 8);
    chk("w3_addr", e_write_address, 32'h30);
    repeat (10) tick();
    ram_init = 1'b0;
    snap_wr = wr_count;
    repeat (200) tick();
    chk("disabled_no_write", 32'(wr_count - snap_wr), 0);
    chk("disabled_ready", rx_ready, 1'b0);
    ram_init = 1'b1;
    send_word(8'hC0);
    chk("reenable_addr", e_write_address, 32'h0);
    chk("reenable_byte0", e_write_data[7:0], 8'hC0);

    // Reset landing on a WRITE cycle.
    send_word(8'h10);
    chk("pre_reset_strobe", e_write_ram, 1'b1);
    reset = 1'b1;
    rx_valid = 1'b0;
    tick();
    chk("reset_strobe", e_write_ram, 1'b0);
    chk("reset_clr_data", e_write_data, '0);
    chk("reset_clr_addr", e_write_address, 32'h0);
    chk("reset_idle_ready", rx_ready, 1'b0);
    reset = 1'b0;
    ram_init = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
